// File: rtl/lc3b_regfile_cc.sv
// Parametrised register file with shared NZP condition codes, optional second
// bank for context switches, combinational reads with optional write bypass.
module lc3b_regfile_cc #(
    parameter int DATA_W    = 16,
    parameter int NUM_REGS  = 8,
    parameter int ADDR_W    = 3,
    parameter int NUM_RD    = 2,
    parameter int NUM_BANKS = 1,
    parameter int BYPASS    = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         wr_byte,
    input  logic                         cc_en,
    input  logic                         clr,
    input  logic                         bank_swap,
    input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0]     rd_data,
    output logic                         n,
    output logic                         z,
    output logic                         p,
    output logic                         bank,
    output logic [NUM_REGS*DATA_W-1:0]   dump
);

    logic [DATA_W-1:0] wv;
    logic              wr_fire;
    logic              bank_q, bank_d;
    logic [2:0]        cc_q, cc_d;          // {n, z, p}

    logic [NUM_REGS-1:0][DATA_W-1:0] bank_img [NUM_BANKS];
    logic [NUM_REGS-1:0][DATA_W-1:0] active_img;

    assign wv      = wr_byte ? {{(DATA_W-8){wr_data[7]}}, wr_data[7:0]} : wr_data;
    assign wr_fire = wr_en && ({1'b0, wr_addr} < (ADDR_W+1)'(NUM_REGS));

    // Storage: each bank only updates while it is the active one, so a
    // same-cycle swap still sees the pre-swap bank for clr and writes.
    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            for (genvar gj = 0; gj < NUM_REGS; gj++) begin : g_reg
                logic [DATA_W-1:0] r_q;
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        r_q <= '0;
                    end else if (bank_q == 1'(gi)) begin
                        if (clr) begin
                            r_q <= '0;
                        end else if (wr_fire && (wr_addr == ADDR_W'(gj))) begin
                            r_q <= wv;
                        end
                    end
                end
                assign bank_img[gi][gj] = r_q;
            end
        end
    endgenerate

    always_comb begin
        cc_d = cc_q;
        if (clr) begin
            cc_d = 3'b010;
        end else if (wr_fire && cc_en) begin
            if (wv[DATA_W-1])     cc_d = 3'b100;
            else if (wv == '0)    cc_d = 3'b010;
            else                  cc_d = 3'b001;
        end
        bank_d = bank_q;
        if ((NUM_BANKS == 2) && bank_swap) bank_d = ~bank_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cc_q   <= 3'b010;
            bank_q <= 1'b0;
        end else begin
            cc_q   <= cc_d;
            bank_q <= bank_d;
        end
    end

    always_comb begin
        active_img = bank_img[0];
        for (int b = 1; b < NUM_BANKS; b++) begin
            if (bank_q == 1'(b)) active_img = bank_img[b];
        end
    end

    // Read ports: out-of-range addresses fall through to zero.
    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] val;
            assign ra = rd_addr[gi*ADDR_W +: ADDR_W];
            always_comb begin
                val = '0;
                for (int r = 0; r < NUM_REGS; r++) begin
                    if (ra == ADDR_W'(r)) val = active_img[r];
                end
                if ((BYPASS != 0) && reset && wr_fire && !clr && (ra == wr_addr)) val = wv;
            end
            assign rd_data[gi*DATA_W +: DATA_W] = val;
        end
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dump
            assign dump[gi*DATA_W +: DATA_W] = active_img[gi];
        end
    endgenerate

    assign n    = cc_q[2];
    assign z    = cc_q[1];
    assign p    = cc_q[0];
    assign bank = bank_q;

endmodule
